// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between N_REQ gate clients and the shared gate arbiter.
// Latency: wires only.
// Backpressure: req_ready gates each requester; rsp_ready stalls the single result slot.
interface gate_op_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   req_a;
    logic [N_REQ-1:0]   req_b;
    logic [3*N_REQ-1:0] req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_y;
    logic               rsp_err;
    logic [CNT_W-1:0]   done_cnt;

    // Client side: issues requests, consumes results.
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_err, done_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_err, done_cnt
    );
endinterface

// File: rtl/gate_op_arbiter.sv
// Round-robin sharing of one combinational gate unit among N_REQ requesters, registered tagged result.
// Latency: result valid one cycle after the accepting edge; one result per cycle sustained.
// Backpressure: all req_ready low while a result is held with rsp_ready low; drain and refill in the same cycle.

// Plain combinational gate bank; every gate output is produced, the caller selects one.
module logic_gates (
    input  logic a,
    input  logic b,
    output logic y_and,
    output logic y_or,
    output logic y_nand,
    output logic y_nor,
    output logic y_not,
    output logic y_xor,
    output logic y_xnor
);
    assign y_and  = a & b;
    assign y_or   = a | b;
    assign y_nand = ~(a & b);
    assign y_nor  = ~(a | b);
    assign y_not  = ~a;
    assign y_xor  = a ^ b;
    assign y_xnor = ~(a ^ b);
endmodule

module gate_op_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    gate_op_arbiter_if.slave  bus
);
    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  srch_idx;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ready_int;
    logic             gnt_any;
    logic             can_accept;
    logic             xfer;
    logic             drain;
    logic             gnt_a;
    logic             gnt_b;
    logic [2:0]       gnt_op;
    logic             sel_y;
    logic             sel_err;
    logic y_and, y_or, y_nand, y_nor, y_not, y_xor, y_xnor;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        srch_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            srch_idx = ID_W'((int'(last) + k) % N_REQ);
            if (!gnt_any && bus.req_valid[srch_idx]) begin
                gnt_any           = 1'b1;
                gnt_idx           = srch_idx;
                grant[srch_idx]   = 1'b1;
            end
        end
    end

    // The result slot can take a new entry when empty or draining this cycle.
    assign can_accept    = !bus.rsp_valid || bus.rsp_ready;
    assign ready_int     = rst ? '0 : (grant & {N_REQ{can_accept}});
    assign bus.req_ready = ready_int;
    assign xfer          = |(bus.req_valid & ready_int);
    assign drain         = bus.rsp_valid && bus.rsp_ready;

    // Operand mux from the granted requester; zeros when nobody is granted.
    always_comb begin
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        gnt_op = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_any && gnt_idx == ID_W'(i)) begin
                gnt_a  = bus.req_a[i];
                gnt_b  = bus.req_b[i];
                gnt_op = bus.req_op[3*i +: 3];
            end
        end
    end

    logic_gates u_gates (
        .a      (gnt_a),
        .b      (gnt_b),
        .y_and  (y_and),
        .y_or   (y_or),
        .y_nand (y_nand),
        .y_nor  (y_nor),
        .y_not  (y_not),
        .y_xor  (y_xor),
        .y_xnor (y_xnor)
    );

    // Pick the gate output named by the op code; code 7 is reserved and flagged.
    always_comb begin
        sel_y   = 1'b0;
        sel_err = 1'b0;
        case (gnt_op)
            3'd0:    sel_y = y_and;
            3'd1:    sel_y = y_or;
            3'd2:    sel_y = y_nand;
            3'd3:    sel_y = y_nor;
            3'd4:    sel_y = y_not;
            3'd5:    sel_y = y_xor;
            3'd6:    sel_y = y_xnor;
            default: sel_err = 1'b1;
        endcase
    end

    // Result register, round-robin pointer and saturating completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_y     <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_id    <= '0;
            bus.done_cnt  <= '0;
            last          <= ID_W'(N_REQ - 1);
        end else begin
            if (xfer) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_y     <= sel_y;
                bus.rsp_err   <= sel_err;
                bus.rsp_id    <= gnt_idx;
                last          <= gnt_idx;
            end else if (drain) begin
                bus.rsp_valid <= 1'b0;
            end
            if (drain && bus.done_cnt != '1) begin
                bus.done_cnt <= bus.done_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_gate_op_arbiter.sv
module tb_gate_op_arbiter;
    localparam int N = 4;

    typedef struct {
        int id;
        bit y;
        bit err;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   rr_log[$];
    int   model_last = N - 1;
    bit   model_full = 0;
    int   exp_cnt    = 0;

    gate_op_arbiter_if #(.N_REQ(4), .ID_W(2), .CNT_W(16)) bus ();
    gate_op_arbiter_if #(.N_REQ(4), .ID_W(2), .CNT_W(2))  bus2 ();

    gate_op_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    gate_op_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Gate truth rules straight from the op-code table.
    function automatic bit ref_gate(input int op, input bit a, input bit b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return !(a & b);
            3: return !(a | b);
            4: return !a;
            5: return a != b;
            6: return a == b;
            default: return 1'b0;
        endcase
    endfunction

    // First valid requester after 'last', wrapping; -1 when none.
    function automatic int pick(input logic [3:0] v, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (v[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    // Reference model: predicts ready, occupancy and counter; pushes expected results.
    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        int   g;
        bit   ok;
        bit   drn;
        exp_t e;
        if (rst) begin
            check("ready_in_reset", {28'd0, bus.req_ready}, 32'd0);
            model_full = 0;
            model_last = N - 1;
            exp_cnt    = 0;
            exp_q.delete();
        end else begin
            check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, model_full});
            check("done_cnt", {16'd0, bus.done_cnt}, exp_cnt);
            ok      = !model_full || bus.rsp_ready;
            g       = pick(bus.req_valid, model_last);
            exp_rdy = 4'd0;
            if (ok && g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_rdy});
            drn = model_full && bus.rsp_ready;
            if (drn && exp_cnt < 65535) exp_cnt++;
            if (exp_rdy != 4'd0) begin
                e.id  = g;
                e.err = (bus.req_op[3*g +: 3] == 3'd7);
                e.y   = ref_gate(int'(bus.req_op[3*g +: 3]), bus.req_a[g], bus.req_b[g]);
                exp_q.push_back(e);
                model_last = g;
                model_full = 1;
            end else if (drn) begin
                model_full = 0;
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check("rsp_id",  {30'd0, bus.rsp_id}, exp_q[0].id);
                check("rsp_y",   {31'd0, bus.rsp_y},  {31'd0, exp_q[0].y});
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_q[0].err});
                if (bus.rsp_ready) begin
                    rr_log.push_back(int'(bus.rsp_id));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] acc;
        int rr_exp[6];
        rr_exp = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1;
        idle();
        bus.rsp_ready  = 1'b1;
        bus2.req_valid = '0;
        bus2.req_a     = '0;
        bus2.req_b     = '0;
        bus2.req_op    = '0;
        bus2.rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_cnt", {16'd0, bus.done_cnt}, 32'd0);

        // Single XOR request from requester 2.
        bus.req_valid   = 4'b0100;
        bus.req_a[2]    = 1'b1;
        bus.req_op[8:6] = 3'd5;
        tick();
        idle();
        check("t1_y", {31'd0, bus.rsp_y}, 32'd1);
        check("t1_id", {30'd0, bus.rsp_id}, 32'd2);
        tick();
        check("t1_done", {16'd0, bus.done_cnt}, 32'd1);

        // Truth sweep on requester 0, back to back.
        do_reset();
        for (int i = 0; i < 28; i++) begin
            bus.req_valid[0] = 1'b1;
            bus.req_a[0]     = i[1];
            bus.req_b[0]     = i[0];
            bus.req_op[2:0]  = 3'(i / 4);
            tick();
        end
        idle();
        tick();
        check("sweep_done", {16'd0, bus.done_cnt}, 32'd28);

        // Round robin with everyone requesting from reset.
        do_reset();
        rr_log.delete();
        bus.req_valid = 4'b1111;
        bus.req_a     = 4'b1010;
        bus.req_b     = 4'b0110;
        bus.req_op    = {3'd1, 3'd5, 3'd2, 3'd0};
        repeat (6) tick();
        idle();
        tick();
        check("rr_len", rr_log.size(), 32'd6);
        for (int j = 0; j < 6; j++) begin
            if (j < rr_log.size()) check("rr_order", rr_log[j], rr_exp[j]);
        end

        // Backpressure: hold the slot for five cycles.
        do_reset();
        bus.req_valid[0] = 1'b1;
        bus.req_a[0]     = 1'b1;
        bus.req_b[0]     = 1'b1;
        tick();
        bus.rsp_ready   = 1'b0;
        bus.req_valid   = 4'b0110;
        bus.req_a       = 4'b0100;
        bus.req_b       = 4'b0010;
        bus.req_op      = {3'd0, 3'd3, 3'd1, 3'd0};
        repeat (5) tick();
        check("bp_cnt", {16'd0, bus.done_cnt}, 32'd0);
        check("bp_id", {30'd0, bus.rsp_id}, 32'd0);
        check("bp_y", {31'd0, bus.rsp_y}, 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 4'b0100;
        tick();
        idle();
        tick();
        tick();

        // Reserved op followed by a normal op from the same requester.
        do_reset();
        bus.req_valid    = 4'b1000;
        bus.req_a[3]     = 1'b1;
        bus.req_b[3]     = 1'b1;
        bus.req_op[11:9] = 3'd7;
        tick();
        check("rsv_err", {31'd0, bus.rsp_err}, 32'd1);
        bus.req_op[11:9] = 3'd0;
        tick();
        idle();
        check("rsv_clear", {31'd0, bus.rsp_err}, 32'd0);
        tick();
        tick();

        // Reset while a result is in flight.
        do_reset();
        bus.req_valid = 4'b1111;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_cnt", {16'd0, bus.done_cnt}, 32'd0);
        repeat (4) tick();
        idle();
        tick();

        // Two-bit counter saturates after three drains.
        bus2.req_valid[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) bus2.req_valid[0] = 1'b0;
            check("sat_cnt", {30'd0, bus2.done_cnt}, (k - 1 > 3) ? 3 : k - 1);
        end

        // Random traffic with held operands, random stalls and rare resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || acc[i]) begin
                    bus.req_valid[i]     = ($urandom_range(0, 2) != 0);
                    bus.req_a[i]         = 1'($urandom_range(0, 1));
                    bus.req_b[i]         = 1'($urandom_range(0, 1));
                    bus.req_op[3*i +: 3] = 3'($urandom_range(0, 7));
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        idle();
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        check("final_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
